// File: rtl/i2c_write24_master_if.sv
// Sequencer-side handshake and SCLK for i2c_write24_master.
// The open-drain SDAT line is a plain inout on the engine so it can be resolved with the bus pull-up.
interface i2c_write24_master_if;
  logic [23:0] I2C_DATA;
  logic        GO;
  logic        END;
  logic [2:0]  ACK;
  logic        I2C_SCLK;

  modport master (
    input  I2C_DATA,
    input  GO,
    output END,
    output ACK,
    output I2C_SCLK
  );

  modport slave (
    output I2C_DATA,
    output GO,
    input  END,
    input  ACK,
    input  I2C_SCLK
  );
endinterface

// File: rtl/i2c_write24_master.sv
// Bit-level I2C write engine: START, three bytes with ack slots, STOP, then GO/END handshake.
// Optional macro I2C_ABORT_ON_NACK_EN: a NACK on byte 0 or 1 skips straight to STOP.
module i2c_write24_master #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic                         clk_i2c,
  input  logic                         reset,
  i2c_write24_master_if.master         bus,
  inout  wire                          I2C_SDAT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_ACKS,
    S_STOP,
    S_DONE
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [1:0]  phase_q, phase_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] shift_q, shift_d;
  logic [2:0]  ack_q, ack_d;

  logic        tick;
  logic        scl;
  logic        sda_low;
  logic        sda_in;

  assign tick   = (div_q == DIV_LAST);
  assign sda_in = I2C_SDAT;

`ifdef I2C_ABORT_ON_NACK_EN
  logic nack_cur;
  always_comb begin
    nack_cur = 1'b0;
    case (byte_cnt_q)
      2'd0:    nack_cur = ack_q[2];
      2'd1:    nack_cur = ack_q[1];
      default: nack_cur = 1'b0;
    endcase
  end
`endif

  always_ff @(posedge clk_i2c) begin
    if (reset) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      phase_q    <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      ack_q      <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      phase_q    <= phase_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      ack_q      <= ack_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    phase_d    = phase_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    ack_d      = ack_q;
    scl        = 1'b1;
    sda_low    = 1'b0;

    // Phase engine runs only inside bus slots; it always leaves STOP at div=0, phase=0.
    if (state_q inside {S_START, S_BIT, S_ACKS, S_STOP}) begin
      if (tick) begin
        div_d   = '0;
        phase_d = phase_q + 2'd1;
      end else begin
        div_d   = div_q + 8'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.GO) begin
          shift_d = bus.I2C_DATA;
          ack_d   = '0;
          div_d   = '0;
          phase_d = '0;
          state_d = S_START;
        end
      end

      S_START: begin
        scl     = (phase_q == 2'd0) || (phase_q == 2'd1);
        sda_low = (phase_q != 2'd0);
        if (tick && phase_q == 2'd3) begin
          bit_cnt_d  = 3'd7;
          byte_cnt_d = 2'd0;
          state_d    = S_BIT;
        end
      end

      S_BIT: begin
        scl     = (phase_q == 2'd1) || (phase_q == 2'd2);
        sda_low = ~shift_q[23];
        if (tick && phase_q == 2'd3) begin
          shift_d = {shift_q[22:0], 1'b0};
          if (bit_cnt_q == 3'd0) begin
            state_d = S_ACKS;
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
          end
        end
      end

      S_ACKS: begin
        scl = (phase_q == 2'd1) || (phase_q == 2'd2);
        if (tick && phase_q == 2'd2) begin
          case (byte_cnt_q)
            2'd0:    ack_d[2] = sda_in;
            2'd1:    ack_d[1] = sda_in;
            default: ack_d[0] = sda_in;
          endcase
        end
        if (tick && phase_q == 2'd3) begin
          if (byte_cnt_q == 2'd2) begin
            state_d = S_STOP;
`ifdef I2C_ABORT_ON_NACK_EN
          end else if (nack_cur) begin
            // Bytes that will never be sent report as NACKed.
            ack_d   = ack_q | ((byte_cnt_q == 2'd0) ? 3'b011 : 3'b001);
            state_d = S_STOP;
`endif
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            bit_cnt_d  = 3'd7;
            state_d    = S_BIT;
          end
        end
      end

      S_STOP: begin
        scl     = (phase_q != 2'd0);
        sda_low = (phase_q == 2'd0) || (phase_q == 2'd1);
        if (tick && phase_q == 2'd3) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (!bus.GO) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.END      = (state_q == S_DONE);
  assign bus.ACK      = ack_q;
  assign bus.I2C_SCLK = scl;
  assign I2C_SDAT     = sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_write24_master.sv
// Directed bench for i2c_write24_master: two instances (CLK_DIV=1 and 3) with an acking slave model.
module tb_i2c_write24_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_write24_master_if bus0 ();
  i2c_write24_master_if bus1 ();

  wire sdat0;
  wire sdat1;
  pullup (sdat0);
  pullup (sdat1);

  logic       drv   [2] = '{1'b0, 1'b0};
  logic [2:0] nmask [2] = '{3'b000, 3'b000};

  assign sdat0 = drv[0] ? 1'b0 : 1'bz;
  assign sdat1 = drv[1] ? 1'b0 : 1'bz;

  i2c_write24_master #(.CLK_DIV(1)) u_dut0 (
    .clk_i2c (clk),
    .reset   (rst),
    .bus     (bus0.master),
    .I2C_SDAT(sdat0)
  );

  i2c_write24_master #(.CLK_DIV(3)) u_dut1 (
    .clk_i2c (clk),
    .reset   (rst),
    .bus     (bus1.master),
    .I2C_SDAT(sdat1)
  );

  int checks = 0;
  int errors = 0;

  // Bus monitor + slave model, sampled on the falling clock edge.
  int         starts [2] = '{0, 0};
  int         stops  [2] = '{0, 0};
  int         rise   [2] = '{0, 0};
  int         nbytes [2] = '{0, 0};
  int         hi_len [2] = '{0, 0};
  int         hi_min [2] = '{1000, 1000};
  int         hi_max [2] = '{0, 0};
  logic [7:0] sh     [2] = '{8'h00, 8'h00};
  logic [7:0] rx     [2][3];
  logic       scl_p  [2] = '{1'b1, 1'b1};
  logic       sda_p  [2] = '{1'b1, 1'b1};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic c;
      logic d;
      c = (i == 0) ? bus0.I2C_SCLK : bus1.I2C_SCLK;
      d = (i == 0) ? sdat0 : sdat1;
      if (scl_p[i] && c && sda_p[i] && !d) begin
        starts[i] = starts[i] + 1;
        rise[i]   = 0;
        nbytes[i] = 0;
        drv[i]    = 1'b0;
        hi_min[i] = 1000;
        hi_max[i] = 0;
      end else if (scl_p[i] && c && !sda_p[i] && d) begin
        stops[i] = stops[i] + 1;
      end
      if (!scl_p[i] && c) begin
        hi_len[i] = 1;
        rise[i]   = rise[i] + 1;
        if (rise[i] % 9 != 0) begin
          sh[i] = {sh[i][6:0], d};
          if (rise[i] % 9 == 8 && nbytes[i] < 3) begin
            rx[i][nbytes[i]] = sh[i];
            nbytes[i] = nbytes[i] + 1;
          end
        end
      end else if (c) begin
        hi_len[i] = hi_len[i] + 1;
      end
      if (scl_p[i] && !c && rise[i] > 0) begin
        if (hi_len[i] < hi_min[i]) hi_min[i] = hi_len[i];
        if (hi_len[i] > hi_max[i]) hi_max[i] = hi_len[i];
        if (rise[i] % 9 == 8 && rise[i] / 9 < 3) begin
          drv[i] = ~nmask[i][2 - rise[i] / 9];
        end else if (rise[i] % 9 == 0) begin
          drv[i] = 1'b0;
        end
      end
      scl_p[i] = c;
      sda_p[i] = d;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input int idx, input logic [23:0] data, input logic go);
    if (idx == 0) begin
      bus0.I2C_DATA = data;
      bus0.GO       = go;
    end else begin
      bus1.I2C_DATA = data;
      bus1.GO       = go;
    end
  endtask

  function automatic logic get_end(input int idx);
    return (idx == 0) ? bus0.END : bus1.END;
  endfunction

  function automatic logic [2:0] get_ack(input int idx);
    return (idx == 0) ? bus0.ACK : bus1.ACK;
  endfunction

  function automatic logic [5:0] bus_state(input int idx);
    if (idx == 0) return {bus0.I2C_SCLK, sdat0, bus0.END, bus0.ACK};
    return {bus1.I2C_SCLK, sdat1, bus1.END, bus1.ACK};
  endfunction

  // Call just after a falling edge: the next rising edge samples GO=1.
  task automatic run_xfer(input int idx, input logic [23:0] data, input logic [2:0] mask,
                          input bit hold, input int exp_cyc, input logic [2:0] exp_ack,
                          input int exp_nb);
    int cyc;
    int st0;
    int sp0;
    logic [23:0] d;
    d   = data;
    st0 = starts[idx];
    sp0 = stops[idx];
    nmask[idx] = mask;
    set_in(idx, data, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_in(idx, ~data, hold);
    cyc = 0;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (get_end(idx)) break;
    end
    check("end_latency", cyc, exp_cyc);
    check("ack", {29'd0, get_ack(idx)}, {29'd0, exp_ack});
    check("nbytes", nbytes[idx], exp_nb);
    for (int b = 0; b < exp_nb; b++) begin
      check("byte", {24'd0, rx[idx][b]}, {24'd0, d[23 - 8 * b -: 8]});
    end
    check("start_cnt", starts[idx] - st0, 1);
    check("stop_cnt", stops[idx] - sp0, 1);
    if (!hold) begin
      @(posedge clk);
      #1;
      check("end_pulse", {31'd0, get_end(idx)}, 32'd0);
    end
  endtask

  initial begin
    int s_hold;
    logic [2:0] pre_mask;
    set_in(0, 24'h0, 1'b0);
    set_in(1, 24'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_state0", {26'd0, bus_state(0)}, 32'h30);
    check("reset_state1", {26'd0, bus_state(1)}, 32'h30);
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      check("idle0", {26'd0, bus_state(0)}, 32'h30);
      check("idle1", {26'd0, bus_state(1)}, 32'h30);
    end

    @(negedge clk);
    run_xfer(0, 24'h341E00, 3'b000, 1'b0, 116, 3'b000, 3);

    @(negedge clk);
    run_xfer(1, 24'h340479, 3'b000, 1'b0, 348, 3'b000, 3);
    check("scl_hi_min", hi_min[1], 6);
    check("scl_hi_max", hi_max[1], 6);

    @(negedge clk);
`ifdef I2C_ABORT_ON_NACK_EN
    run_xfer(0, 24'h340C00, 3'b010, 1'b0, 80, 3'b011, 2);
`else
    run_xfer(0, 24'h340C00, 3'b010, 1'b0, 116, 3'b010, 3);
`endif

    @(negedge clk);
    run_xfer(0, 24'h12AB55, 3'b000, 1'b1, 116, 3'b000, 3);
    s_hold = starts[0];
    for (int n = 0; n < 50; n++) begin
      @(posedge clk);
      #1;
      check("hold_end_scl", {30'd0, bus0.END, bus0.I2C_SCLK}, 32'd3);
    end
    check("hold_no_restart", starts[0], s_hold);
    @(negedge clk);
    set_in(0, 24'h0, 1'b0);
    @(posedge clk);
    #1;
    check("end_drop", {31'd0, bus0.END}, 32'd0);
    @(negedge clk);
    run_xfer(0, 24'hA5F00F, 3'b000, 1'b0, 116, 3'b000, 3);

    // Reset lands in byte 1, bit 4 (slot 13 at CLK_DIV=1).
`ifdef I2C_ABORT_ON_NACK_EN
    pre_mask = 3'b000;
`else
    pre_mask = 3'b100;
`endif
    @(negedge clk);
    nmask[0] = pre_mask;
    set_in(0, 24'h5A3C96, 1'b1);
    @(posedge clk);
    repeat (54) @(posedge clk);
    #1;
    check("pre_reset_ack", {29'd0, bus0.ACK}, {29'd0, pre_mask});
    check("pre_reset_busy", {31'd0, bus0.END}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_reset", {26'd0, bus_state(0)}, 32'h30);
    @(negedge clk);
    rst = 1'b0;
    run_xfer(0, 24'h5A3C96, 3'b000, 1'b0, 116, 3'b000, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
